vga_sprite_compositor: RTL and testbench
========================================

VGA_SPRITE_COMPOSITOR -- requirements
Module: vga_sprite_compositor

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter NUM_SPR, 2, sprite channel count (1..8).
REQ-006 SHALL have parameters SPR_W/SPR_H, 64/64, sprite size in pixels; AW = clog2(SPR_W*SPR_H).
REQ-007 SHALL have parameter X_OFS, 256, world-x offset added to the screen column.
REQ-008 SHALL have parameters BG_COLOR, 24'h555555, and KEY_COLOR, 24'h000000 (transparent colour), both in {B,G,R} order.
REQ-009 Ports: iVGA_CLK  in  1  pixel clock; the only clock.
REQ-010 Ports: iRST  in  1  reset; synchronous, active-high.
REQ-011 Ports: iSPR_X, iSPR_Y  in  NUM_SPR*11 each  sprite top-left in world coordinates; channel n occupies bits [11n+10:11n].
REQ-012 Ports: iSPR_EN, iSPR_FLIP  in  NUM_SPR each  per-sprite enable and horizontal-mirror request.
REQ-013 Ports: oROM_ADDR  out  NUM_SPR*AW  per-sprite pixel address; iROM_DATA  in  NUM_SPR*24  ROM colour, valid exactly 1 clock after the address.
REQ-014 Ports: oHS, oVS, oBLANK_n  out  1 each  active-low syncs and blanking flag; oB, oG, oR  out  8 each  colour; oFRAME  out  1  one-clock pulse at the first vertical-blank line.

Function
REQ-015 Counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1 (TOTAL = sum of the four fields) SHALL advance every clock: h wraps to 0 and increments v, and v wraps to 0 after V_TOTAL-1.
REQ-016 Active area SHALL be h<H_ACTIVE and v<V_ACTIVE; HS SHALL be low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and VS likewise on v.
REQ-017 Sprite inputs SHALL be sampled into shadow registers only at h==0 and v==V_ACTIVE, the same cycle oFRAME pulses, so that no frame tears.
REQ-018 Stage 1: with sx = X_OFS+h and sy = v (11-bit, no wrap), sprite n hits when it is enabled, X<=sx<X+SPR_W and Y<=sy<Y+SPR_H, compared at 12-bit width.
REQ-019 Stage 1: the registered address SHALL be (sy-Y)*SPR_W+(sx-X); on a miss the address SHALL be 0.
REQ-020 Stage 2 SHALL receive iROM_DATA together with the hit flags delayed by one clock.
REQ-021 Stage 3 SHALL output the lowest-index sprite that hits and whose data is not KEY_COLOR; if none qualifies, it SHALL output BG_COLOR.
REQ-022 Outside the active area, colour SHALL be 0 whatever the hit results.
REQ-023 oHS, oVS and oBLANK_n SHALL be delayed 3 clocks, so they align with colour; total pixel latency is 3 clocks from the counter value.
REQ-024 A sprite partly beyond the right or bottom edge SHALL be clipped: only in-area pixels hit, and no address exceeds SPR_W*SPR_H-1.
REQ-025 Simultaneous hits from different sprites SHALL resolve only by REQ-021 priority; colours SHALL never be blended.

Reset
REQ-026 While iRST is high at a clock edge, h, v, shadow registers and pipeline registers SHALL clear to 0.
REQ-027 While iRST is high, outputs SHALL be oHS=1, oVS=1, oBLANK_n=0, colour=0, oFRAME=0 and oROM_ADDR=0.
REQ-028 After deassertion, the first active pixel SHALL appear 3 clocks after iRST falls; sprites SHALL remain disabled until the first oFRAME.
REQ-029 Reset asserted mid-line SHALL abort the frame immediately, with no partial-line completion.

Configuration
REQ-030 With macro SPRITE_HFLIP_EN defined and iSPR_FLIP[n]=1, the column term SHALL be SPR_W-1-(sx-X), mirroring the sprite.
REQ-031 Without SPRITE_HFLIP_EN, iSPR_FLIP SHALL be ignored and the flip logic SHALL be absent.

Verification
REQ-032 After reset release, count clocks between oVS falling edges -> 800*525 = 420000; oHS low width = 96 clocks.
REQ-033 Sprite 0 at X=300, Y=10, enabled, ROM returns 24'h0000FF -> pixel (h=44, v=10) shows R=FF, G=00, B=00 three clocks later; pixel h=43 shows BG 55/55/55.
REQ-034 Sprites 0 and 1 both at X=300, Y=10 -> overlap shows sprite 0; with sprite 0 data = KEY_COLOR -> shows sprite 1.
REQ-035 iSPR_X changed mid-frame at v=100 -> no change before oFRAME; new position takes effect from the next frame's v=0.
REQ-036 SPRITE_HFLIP_EN build, FLIP=1, X=300 -> at h=44, oROM_ADDR for row 0 = 63; with the macro undefined -> 0.
REQ-037 iRST pulsed at h=200, v=50 -> the next clock shows oBLANK_n=0 and colour 0; counters restart from h=0, v=0.

Source files
------------

// File: rtl/vga_sprite_compositor_if.sv
// Sprite-position and sprite-ROM bus between the compositor (master) and its
// sprite source / colour ROM (slave).
interface vga_sprite_compositor_if #(
  parameter int unsigned NUM_SPR = 2,
  parameter int unsigned AW      = 12
);
  logic [NUM_SPR*11-1:0] iSPR_X;
  logic [NUM_SPR*11-1:0] iSPR_Y;
  logic [NUM_SPR-1:0]    iSPR_EN;
  logic [NUM_SPR-1:0]    iSPR_FLIP;
  logic [NUM_SPR*AW-1:0] oROM_ADDR;
  logic [NUM_SPR*24-1:0] iROM_DATA;

  modport master (
    input  iSPR_X, iSPR_Y, iSPR_EN, iSPR_FLIP, iROM_DATA,
    output oROM_ADDR
  );

  modport slave (
    output iSPR_X, iSPR_Y, iSPR_EN, iSPR_FLIP, iROM_DATA,
    input  oROM_ADDR
  );
endinterface

// File: rtl/vga_sprite_compositor.sv
// VGA timing generator with NUM_SPR hardware sprites composited over a flat
// background. Optional horizontal mirroring is built when SPRITE_HFLIP_EN is defined.
module vga_sprite_compositor #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned NUM_SPR   = 2,
  parameter int unsigned SPR_W     = 64,
  parameter int unsigned SPR_H     = 64,
  parameter int unsigned X_OFS     = 256,
  parameter logic [23:0] BG_COLOR  = 24'h555555,
  parameter logic [23:0] KEY_COLOR = 24'h000000
) (
  input  logic                    iVGA_CLK,
  input  logic                    iRST,
  vga_sprite_compositor_if.master bus,
  output logic                    oHS,
  output logic                    oVS,
  output logic                    oBLANK_n,
  output logic [7:0]              oB,
  output logic [7:0]              oG,
  output logic [7:0]              oR,
  output logic                    oFRAME
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned AW      = $clog2(SPR_W * SPR_H);
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0]           r_h;
  logic [VW-1:0]           r_v;
  logic [NUM_SPR*11-1:0]   r_spr_x;
  logic [NUM_SPR*11-1:0]   r_spr_y;
  logic [NUM_SPR-1:0]      r_spr_en;
`ifdef SPRITE_HFLIP_EN
  logic [NUM_SPR-1:0]      r_spr_flip;
`endif
  logic [NUM_SPR*AW-1:0]   r_addr;
  logic [NUM_SPR-1:0]      r_hit1;
  logic [NUM_SPR-1:0]      r_hit2;
  logic [2:0]              r_hs_sr;
  logic [2:0]              r_vs_sr;
  logic [2:0]              r_blank_sr;
  logic [23:0]             r_color;
  logic                    r_frame;

  logic [31:0]             w_hcnt;
  logic [31:0]             w_vcnt;
  logic                    w_active;
  logic                    w_hs_n;
  logic                    w_vs_n;
  logic                    w_frame;
  logic [11:0]             w_sx;
  logic [11:0]             w_sy;
  logic [NUM_SPR-1:0]      w_hit;
  logic [NUM_SPR*AW-1:0]   w_addr;
  logic [23:0]             w_pix;

  assign w_hcnt   = 32'(r_h);
  assign w_vcnt   = 32'(r_v);
  assign w_active = (w_hcnt < H_ACTIVE) && (w_vcnt < V_ACTIVE);
  assign w_hs_n   = !((w_hcnt >= HS_BEG) && (w_hcnt < HS_END));
  assign w_vs_n   = !((w_vcnt >= VS_BEG) && (w_vcnt < VS_END));
  assign w_frame  = (w_hcnt == 32'd0) && (w_vcnt == V_ACTIVE);

  // World coordinates, widened to 12 bits so X+SPR_W never wraps in the compare
  assign w_sx = {1'b0, 11'(X_OFS) + 11'(r_h)};
  assign w_sy = {1'b0, 11'(r_v)};

  for (genvar n = 0; n < NUM_SPR; n++) begin : g_spr
    logic [11:0] w_x;
    logic [11:0] w_y;
    logic [11:0] w_dx;
    logic [11:0] w_dy;
    logic [11:0] w_col;
    logic [23:0] w_lin;

    assign w_x  = {1'b0, r_spr_x[n*11 +: 11]};
    assign w_y  = {1'b0, r_spr_y[n*11 +: 11]};
    assign w_dx = w_sx - w_x;
    assign w_dy = w_sy - w_y;
    assign w_hit[n] = r_spr_en[n]
                   && (w_sx >= w_x) && (w_sx < w_x + 12'(SPR_W))
                   && (w_sy >= w_y) && (w_sy < w_y + 12'(SPR_H));
`ifdef SPRITE_HFLIP_EN
    assign w_col = r_spr_flip[n] ? (12'(SPR_W - 1) - w_dx) : w_dx;
`else
    assign w_col = w_dx;
`endif
    assign w_lin = 24'(w_dy) * 24'(SPR_W) + 24'(w_col);
    // Misses present address 0 so the ROM never sees an out-of-range index
    assign w_addr[n*AW +: AW] = w_hit[n] ? AW'(w_lin) : '0;
  end

  // Lowest-index opaque sprite wins; no blending
  always_comb begin
    w_pix = BG_COLOR;
    for (int n = int'(NUM_SPR) - 1; n >= 0; n--) begin
      if (r_hit2[n] && (bus.iROM_DATA[n*24 +: 24] != KEY_COLOR)) begin
        w_pix = bus.iROM_DATA[n*24 +: 24];
      end
    end
  end

  // Raster counters and frame-synchronous sprite shadow registers
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_h      <= '0;
      r_v      <= '0;
      r_spr_x  <= '0;
      r_spr_y  <= '0;
      r_spr_en <= '0;
`ifdef SPRITE_HFLIP_EN
      r_spr_flip <= '0;
`endif
      r_frame  <= 1'b0;
    end else begin
      if (w_hcnt == H_TOTAL - 1) begin
        r_h <= '0;
        if (w_vcnt == V_TOTAL - 1) r_v <= '0;
        else                       r_v <= r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
      if (w_frame) begin
        r_spr_x  <= bus.iSPR_X;
        r_spr_y  <= bus.iSPR_Y;
        r_spr_en <= bus.iSPR_EN;
`ifdef SPRITE_HFLIP_EN
        r_spr_flip <= bus.iSPR_FLIP;
`endif
      end
      r_frame <= w_frame;
    end
  end

  // Three-stage pixel pipeline: hit/address, ROM wait, select
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_addr     <= '0;
      r_hit1     <= '0;
      r_hit2     <= '0;
      r_hs_sr    <= 3'b111;
      r_vs_sr    <= 3'b111;
      r_blank_sr <= 3'b000;
      r_color    <= '0;
    end else begin
      r_addr     <= w_addr;
      r_hit1     <= w_hit;
      r_hit2     <= r_hit1;
      r_hs_sr    <= {r_hs_sr[1:0], w_hs_n};
      r_vs_sr    <= {r_vs_sr[1:0], w_vs_n};
      r_blank_sr <= {r_blank_sr[1:0], w_active};
      r_color    <= r_blank_sr[1] ? w_pix : 24'h000000;
    end
  end

  assign bus.oROM_ADDR = r_addr;
  assign oHS           = r_hs_sr[2];
  assign oVS           = r_vs_sr[2];
  assign oBLANK_n      = r_blank_sr[2];
  assign oB            = r_color[23:16];
  assign oG            = r_color[15:8];
  assign oR            = r_color[7:0];
  assign oFRAME        = r_frame;

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Directed bench for vga_sprite_compositor using a shrunken raster (136x44 clocks)
// and a registered one-cycle ROM model.
module tb_vga_sprite_compositor;

  localparam int H_ACT = 128, H_FP = 2, H_SY = 4, H_BP = 2;
  localparam int V_ACT = 40,  V_FP = 1, V_SY = 2, V_BP = 1;
  localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
  localparam int BOUND = 15000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs, vs, blank_n, frame;
  logic [7:0] ob, og, orr;
  logic [23:0] rom_col0 = 24'h0000FF;
  logic [23:0] rom_col1 = 24'h00FF00;
  int mh = 0, mv = 0;
  int n_cmp = 0, n_err = 0;

  vga_sprite_compositor_if #(.NUM_SPR(2), .AW(12)) bus ();

  vga_sprite_compositor #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
    .NUM_SPR(2), .SPR_W(64), .SPR_H(64), .X_OFS(256),
    .BG_COLOR(24'h555555), .KEY_COLOR(24'h000000)
  ) dut (
    .iVGA_CLK(clk), .iRST(rst), .bus(bus),
    .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
    .oB(ob), .oG(og), .oR(orr), .oFRAME(frame)
  );

  always #5 clk = ~clk;

  // Reference raster position and synchronous ROM (data one clock after address)
  always @(posedge clk) begin
    if (rst) begin
      mh <= 0; mv <= 0;
    end else if (mh == H_TOT - 1) begin
      mh <= 0; mv <= (mv == V_TOT - 1) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
    bus.iROM_DATA <= {rom_col1, rom_col0};
  end

  task automatic set_spr(input int x0, input int y0, input int x1, input int y1,
                         input logic [1:0] en, input logic [1:0] flip);
    bus.iSPR_X    = {11'(x1), 11'(x0)};
    bus.iSPR_Y    = {11'(y1), 11'(y0)};
    bus.iSPR_EN   = en;
    bus.iSPR_FLIP = flip;
  endtask

  task automatic goto(input int th, input int tv);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!(mh == th && mv == tv) && k < BOUND);
    if (!(mh == th && mv == tv)) begin
      n_cmp++; n_err++;
      $display("FAIL goto(%0d,%0d): timed out at h=%0d v=%0d", th, tv, mh, mv);
    end
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (frame !== 1'b1 && k < BOUND);
    if (frame !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL wait_frame: no oFRAME within %0d clocks", BOUND);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (hs !== 1'b1) begin n_err++; $display("FAIL rst_hs: got %b want 1", hs); end
    n_cmp++; if (vs !== 1'b1) begin n_err++; $display("FAIL rst_vs: got %b want 1", vs); end
    n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL rst_blank: got %b want 0", blank_n); end
    n_cmp++; if ({ob, og, orr} !== 24'h0) begin n_err++; $display("FAIL rst_color: got %h want 000000", {ob, og, orr}); end
    n_cmp++; if (frame !== 1'b0) begin n_err++; $display("FAIL rst_frame: got %b want 0", frame); end
    n_cmp++; if (bus.oROM_ADDR !== 24'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus.oROM_ADDR); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL rel_blank2: got %b want 0", blank_n); end
    @(negedge clk);
    n_cmp++; if (blank_n !== 1'b1) begin n_err++; $display("FAIL rel_blank3: got %b want 1", blank_n); end
    n_cmp++; if ({ob, og, orr} !== 24'h555555) begin n_err++; $display("FAIL rel_bg: got %h want 555555", {ob, og, orr}); end
  endtask

  task automatic test_timing();
    int k, per, vlow, hlow, nfr, w;
    logic prev;
    k = 0; prev = vs;
    while (k < BOUND) begin
      @(negedge clk); k++;
      if (prev && !vs) break;
      prev = vs;
    end
    per = 0; vlow = 0; hlow = 0; nfr = 0; prev = vs;
    while (per < BOUND) begin
      @(negedge clk); per++;
      vlow += (vs == 1'b0) ? 1 : 0;
      hlow += (hs == 1'b0) ? 1 : 0;
      nfr  += (frame == 1'b1) ? 1 : 0;
      if (prev && !vs) break;
      prev = vs;
    end
    n_cmp++; if (per != H_TOT * V_TOT) begin n_err++; $display("FAIL vs_period: got %0d want %0d", per, H_TOT * V_TOT); end
    n_cmp++; if (vlow != V_SY * H_TOT) begin n_err++; $display("FAIL vs_low: got %0d want %0d", vlow, V_SY * H_TOT); end
    n_cmp++; if (hlow != H_SY * V_TOT) begin n_err++; $display("FAIL hs_low_total: got %0d want %0d", hlow, H_SY * V_TOT); end
    n_cmp++; if (nfr != 1) begin n_err++; $display("FAIL frame_pulses: got %0d want 1", nfr); end
    k = 0; prev = hs;
    while (k < BOUND) begin
      @(negedge clk); k++;
      if (prev && !hs) break;
      prev = hs;
    end
    w = 1;
    while (w < 1000) begin
      @(negedge clk);
      if (hs) break;
      w++;
    end
    n_cmp++; if (w != H_SY) begin n_err++; $display("FAIL hs_width: got %0d want %0d", w, H_SY); end
  endtask

  task automatic test_sprite_basic();
    set_spr(300, 10, 0, 0, 2'b01, 2'b00);
    rom_col0 = 24'h0000FF;
    wait_frame();
    goto(43, 12);
    @(negedge clk);
    n_cmp++; if (bus.oROM_ADDR[11:0] !== 12'd0) begin n_err++; $display("FAIL addr_miss: got %0d want 0", bus.oROM_ADDR[11:0]); end
    @(negedge clk);
    n_cmp++; if (bus.oROM_ADDR[11:0] !== 12'd128) begin n_err++; $display("FAIL addr_r2c0: got %0d want 128", bus.oROM_ADDR[11:0]); end
    @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h555555) begin n_err++; $display("FAIL pix_h43: got %h want 555555", {ob, og, orr}); end
    n_cmp++; if (bus.oROM_ADDR[11:0] !== 12'd129) begin n_err++; $display("FAIL addr_r2c1: got %0d want 129", bus.oROM_ADDR[11:0]); end
    @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h0000FF) begin n_err++; $display("FAIL pix_h44: got %h want 0000ff", {ob, og, orr}); end
    goto(107, 12);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h0000FF) begin n_err++; $display("FAIL pix_h107: got %h want 0000ff", {ob, og, orr}); end
    @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h555555) begin n_err++; $display("FAIL pix_h108: got %h want 555555", {ob, og, orr}); end
  endtask

  task automatic test_priority();
    set_spr(300, 10, 300, 10, 2'b11, 2'b00);
    rom_col0 = 24'h0000FF; rom_col1 = 24'h00FF00;
    wait_frame();
    goto(50, 15);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h0000FF) begin n_err++; $display("FAIL prio_s0: got %h want 0000ff", {ob, og, orr}); end
    rom_col0 = 24'h000000;
    goto(60, 15);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h00FF00) begin n_err++; $display("FAIL prio_key_s1: got %h want 00ff00", {ob, og, orr}); end
    rom_col1 = 24'h000000;
    goto(70, 15);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h555555) begin n_err++; $display("FAIL prio_all_key: got %h want 555555", {ob, og, orr}); end
    rom_col0 = 24'h0000FF; rom_col1 = 24'h00FF00;
  endtask

  task automatic test_clip();
    set_spr(370, 20, 0, 0, 2'b01, 2'b00);
    wait_frame();
    goto(127, 20);
    @(negedge clk);
    n_cmp++; if (bus.oROM_ADDR[11:0] !== 12'd13) begin n_err++; $display("FAIL clip_addr127: got %0d want 13", bus.oROM_ADDR[11:0]); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h0000FF) begin n_err++; $display("FAIL clip_pix127: got %h want 0000ff", {ob, og, orr}); end
    @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h000000) begin n_err++; $display("FAIL clip_pix128: got %h want 000000", {ob, og, orr}); end
    n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL clip_blank128: got %b want 0", blank_n); end
    goto(H_TOT - 1, 20);
    @(negedge clk);
    n_cmp++; if (bus.oROM_ADDR[11:0] !== 12'd21) begin n_err++; $display("FAIL clip_addr_end: got %0d want 21", bus.oROM_ADDR[11:0]); end
  endtask

  task automatic test_shadow();
    set_spr(300, 10, 0, 0, 2'b01, 2'b00);
    wait_frame();
    goto(0, 20);
    set_spr(310, 10, 0, 0, 2'b01, 2'b00);
    goto(44, 25);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h0000FF) begin n_err++; $display("FAIL shadow_old: got %h want 0000ff", {ob, og, orr}); end
    wait_frame();
    goto(44, 10);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h555555) begin n_err++; $display("FAIL shadow_new_h44: got %h want 555555", {ob, og, orr}); end
    goto(54, 10);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h0000FF) begin n_err++; $display("FAIL shadow_new_h54: got %h want 0000ff", {ob, og, orr}); end
  endtask

  task automatic test_flip();
    logic [11:0] exp_a;
`ifdef SPRITE_HFLIP_EN
    exp_a = 12'd63;
`else
    exp_a = 12'd0;
`endif
    set_spr(300, 10, 0, 0, 2'b01, 2'b01);
    wait_frame();
    goto(44, 10);
    @(negedge clk);
    n_cmp++; if (bus.oROM_ADDR[11:0] !== exp_a) begin n_err++; $display("FAIL flip_addr: got %0d want %0d", bus.oROM_ADDR[11:0], exp_a); end
    set_spr(300, 10, 0, 0, 2'b01, 2'b00);
  endtask

  task automatic test_midreset();
    wait_frame();
    goto(100, 20);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL mrst_blank: got %b want 0", blank_n); end
    n_cmp++; if ({ob, og, orr} !== 24'h0) begin n_err++; $display("FAIL mrst_color: got %h want 000000", {ob, og, orr}); end
    n_cmp++; if (bus.oROM_ADDR !== 24'h0) begin n_err++; $display("FAIL mrst_addr: got %h want 0", bus.oROM_ADDR); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL mrst_rel2: got %b want 0", blank_n); end
    @(negedge clk);
    n_cmp++; if (blank_n !== 1'b1) begin n_err++; $display("FAIL mrst_rel3: got %b want 1", blank_n); end
    goto(44, 10);
    repeat (3) @(negedge clk);
    n_cmp++; if ({ob, og, orr} !== 24'h555555) begin n_err++; $display("FAIL mrst_spr_off: got %h want 555555", {ob, og, orr}); end
  endtask

  initial begin
    set_spr(0, 0, 0, 0, 2'b00, 2'b00);
    test_reset();
    test_timing();
    test_sprite_basic();
    test_priority();
    test_clip();
    test_shadow();
    test_flip();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
